// File: rtl/param_dp_ram.sv
// -----------------------------------------------------------------------------
// param_dp_ram
//   Simple dual-port RAM: one write port and one read port on a single clock.
//   Per-byte write enables, selectable read-during-write behaviour, an optional
//   output register, a read-valid strobe, a same-address collision flag, and a
//   sequential clear of the whole array after reset.
//
// Parameters
//   DATA_W     word width in bits, multiple of 8 (DATA_W/8 byte lanes)
//   ADDR_W     address width, DEPTH = 2**ADDR_W words
//   RDW_MODE   same-address read during write: 0 = old word, 1 = merged new word
//   OUT_REG    0 = read latency 1, 1 = read latency 2
//   INIT_CLEAR 1 = zero every word after reset, 0 = contents left undefined
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   we         write enable
//   wr_addr    write address
//   wr_data    write data
//   wr_be      byte-lane write enables, lane i = bits [8i+7:8i]
//   re         read enable
//   rd_addr    read address
//   rd_data    registered read data; holds its value between reads
//   rd_valid   one-cycle strobe, rd_data carries a read result
//   init_done  memory ready; we/re are ignored while low
//   collision  aligned with rd_valid: that read hit the same-cycle write address
// -----------------------------------------------------------------------------
module param_dp_ram #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  init_done,
  output logic                  collision
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q,     state_d;
  logic [ADDR_W-1:0] clr_ptr_q,   clr_ptr_d;
  logic              init_done_q, init_done_d;

  logic signed [DATA_W-1:0] rd_data_p0_q, rd_data_p0_d;
  logic                     vld_p0_q,     vld_p0_d;
  logic                     col_p0_q,     col_p0_d;
  logic signed [DATA_W-1:0] rd_data_p1_q, rd_data_p1_d;
  logic                     vld_p1_q,     vld_p1_d;
  logic                     col_p1_q,     col_p1_d;

  logic              clr_en;
  logic              wr_en;
  logic              rd_en;
  logic              col_hit;
  logic [DATA_W-1:0] rd_old;
  logic [DATA_W-1:0] rd_new;

  // Accesses are only honoured once the clear has finished.
  assign wr_en  = init_done_q & we;
  assign rd_en  = init_done_q & re;
  // Gate on reset so a held reset does not keep rewriting word 0.
  assign clr_en = (state_q == ST_INIT) & ~reset;

  // Init sequencer: INIT walks the clear pointer, RUN is terminal.
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    init_done_d = init_done_q;
    if (state_q == ST_INIT) begin
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == LAST_ADDR) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end else begin
      init_done_d = 1'b1;
    end
  end

  // Read-side word selection and collision detect.
  always_comb begin
    rd_old  = mem[rd_addr];
    col_hit = rd_en & wr_en & (rd_addr == wr_addr) & (|wr_be);
    rd_new  = rd_old;
    for (int i = 0; i < BE_W; i++) begin
      if (col_hit && wr_be[i]) begin
        rd_new[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  // ---- stage p0: array read register ----
  always_comb begin
    rd_data_p0_d = rd_data_p0_q;
    vld_p0_d     = rd_en;
    col_p0_d     = col_hit;
    if (rd_en) begin
      rd_data_p0_d = (RDW_MODE != 0) ? rd_new : rd_old;
    end
  end

  // ---- stage p1: optional output register ----
  always_comb begin
    rd_data_p1_d = rd_data_p1_q;
    vld_p1_d     = vld_p0_q;
    col_p1_d     = col_p0_q;
    if (vld_p0_q) begin
      rd_data_p1_d = rd_data_p0_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
      clr_ptr_q    <= '0;
      init_done_q  <= 1'b0;
      rd_data_p0_q <= '0;
      vld_p0_q     <= 1'b0;
      col_p0_q     <= 1'b0;
      rd_data_p1_q <= '0;
      vld_p1_q     <= 1'b0;
      col_p1_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      init_done_q  <= init_done_d;
      rd_data_p0_q <= rd_data_p0_d;
      vld_p0_q     <= vld_p0_d;
      col_p0_q     <= col_p0_d;
      rd_data_p1_q <= rd_data_p1_d;
      vld_p1_q     <= vld_p1_d;
      col_p1_q     <= col_p1_d;
    end
  end

  // Storage array: no reset; cleared by the sequencer, written per byte lane.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_ptr_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  assign rd_data   = (OUT_REG != 0) ? rd_data_p1_q : rd_data_p0_q;
  assign rd_valid  = (OUT_REG != 0) ? vld_p1_q     : vld_p0_q;
  assign collision = (OUT_REG != 0) ? col_p1_q     : col_p0_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_param_dp_ram.sv
// -----------------------------------------------------------------------------
// tb_param_dp_ram
//   Four instances share one stimulus stream:
//     a: RDW_MODE=0 OUT_REG=0   b: RDW_MODE=1 OUT_REG=0
//     c: RDW_MODE=0 OUT_REG=1   d: INIT_CLEAR=0 (init_done only)
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_param_dp_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        re;
  logic [3:0]  rd_addr;

  logic [15:0] rd_data_a, rd_data_b, rd_data_c, rd_data_d;
  logic        rd_valid_a, rd_valid_b, rd_valid_c, rd_valid_d;
  logic        init_done_a, init_done_b, init_done_c, init_done_d;
  logic        collision_a, collision_b, collision_c, collision_d;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  param_dp_ram #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(0), .OUT_REG(0), .INIT_CLEAR(1)) dut_a (
    .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .re(re), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .init_done(init_done_a), .collision(collision_a));

  param_dp_ram #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(1), .OUT_REG(0), .INIT_CLEAR(1)) dut_b (
    .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .re(re), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .init_done(init_done_b), .collision(collision_b));

  param_dp_ram #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(0), .OUT_REG(1), .INIT_CLEAR(1)) dut_c (
    .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .re(re), .rd_addr(rd_addr), .rd_data(rd_data_c), .rd_valid(rd_valid_c),
    .init_done(init_done_c), .collision(collision_c));

  param_dp_ram #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(0), .OUT_REG(0), .INIT_CLEAR(0)) dut_d (
    .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .re(re), .rd_addr(rd_addr), .rd_data(rd_data_d), .rd_valid(rd_valid_d),
    .init_done(init_done_d), .collision(collision_d));

  typedef struct packed {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [1:0]  be;
    logic        re;
    logic [3:0]  ra;
    logic        ev;    // expected rd_valid (latency-1 instances)
    logic [15:0] ed;    // expected rd_data, RDW_MODE=0
    logic        ec;    // expected collision
    logic [15:0] ed_b;  // expected rd_data, RDW_MODE=1
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0; re = 1'b0; rd_addr = '0;
  endtask

  logic        pv;
  logic [15:0] pd;
  logic        pc;

  initial begin
    //             we    wa     wd        be     re    ra     ev    ed        ec    ed_b
    vecs[0]  = '{1'b1, 4'd5, 16'hABCD, 2'b11, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 4'd5, 16'h0012, 2'b01, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd5, 1'b1, 16'hAB12, 1'b0, 16'hAB12};
    vecs[3]  = '{1'b1, 4'd7, 16'h1111, 2'b11, 1'b0, 4'd0, 1'b0, 16'hAB12, 1'b0, 16'hAB12};
    vecs[4]  = '{1'b1, 4'd7, 16'h2222, 2'b10, 1'b1, 4'd7, 1'b1, 16'h1111, 1'b1, 16'h2211};
    vecs[5]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd7, 1'b1, 16'h2211, 1'b0, 16'h2211};
    vecs[6]  = '{1'b1, 4'd7, 16'h3333, 2'b00, 1'b1, 4'd7, 1'b1, 16'h2211, 1'b0, 16'h2211};
    vecs[7]  = '{1'b1, 4'd9, 16'hBEEF, 2'b11, 1'b1, 4'd7, 1'b1, 16'h2211, 1'b0, 16'h2211};
    vecs[8]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd9, 1'b1, 16'hBEEF, 1'b0, 16'hBEEF};
    vecs[9]  = '{1'b1, 4'd9, 16'h5566, 2'b01, 1'b1, 4'd9, 1'b1, 16'hBEEF, 1'b1, 16'hBE66};
    vecs[10] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b0, 16'hBEEF, 1'b0, 16'hBE66};

    // Reset state
    idle_inputs();
    reset = 1'b1;
    re = 1'b1; rd_addr = 4'd3;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_data_a", 32'(rd_data_a), 32'h0);
    chk("rst_rd_valid_a", 32'(rd_valid_a), 32'h0);
    chk("rst_init_done_a", 32'(init_done_a), 32'h0);
    chk("rst_collision_a", 32'(collision_a), 32'h0);
    chk("rst_rd_valid_c", 32'(rd_valid_c), 32'h0);
    chk("rst_init_done_d", 32'(init_done_d), 32'h0);

    // Init: re held high, init_done rises on edge 16, reads ignored until then
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("init_done_a_e%0d", i), 32'(init_done_a), 32'(i == 16));
      chk($sformatf("init_rd_valid_a_e%0d", i), 32'(rd_valid_a), 32'h0);
      chk($sformatf("init_done_d_e%0d", i), 32'(init_done_d), 32'h1);
    end
    step();
    chk("first_read_valid_a", 32'(rd_valid_a), 32'h1);
    chk("first_read_data_a", 32'(rd_data_a), 32'h0);
    chk("first_read_col_a", 32'(collision_a), 32'h0);
    chk("first_read_valid_b", 32'(rd_valid_b), 32'h1);
    chk("first_read_valid_c_lat2", 32'(rd_valid_c), 32'h0);
    pv = 1'b1; pd = 16'h0000; pc = 1'b0;

    // Table-driven byte-lane / collision / hold vectors
    for (int k = 0; k < 11; k++) begin
      we = vecs[k].we; wr_addr = vecs[k].wa; wr_data = vecs[k].wd; wr_be = vecs[k].be;
      re = vecs[k].re; rd_addr = vecs[k].ra;
      step();
      chk($sformatf("v%0d_valid_a", k), 32'(rd_valid_a), 32'(vecs[k].ev));
      chk($sformatf("v%0d_data_a", k), 32'(rd_data_a), 32'(vecs[k].ed));
      chk($sformatf("v%0d_col_a", k), 32'(collision_a), 32'(vecs[k].ec));
      chk($sformatf("v%0d_valid_b", k), 32'(rd_valid_b), 32'(vecs[k].ev));
      chk($sformatf("v%0d_data_b", k), 32'(rd_data_b), 32'(vecs[k].ed_b));
      chk($sformatf("v%0d_col_b", k), 32'(collision_b), 32'(vecs[k].ec));
      // OUT_REG=1 instance shows the previous row's result
      chk($sformatf("v%0d_valid_c", k), 32'(rd_valid_c), 32'(pv));
      chk($sformatf("v%0d_data_c", k), 32'(rd_data_c), 32'(pd));
      chk($sformatf("v%0d_col_c", k), 32'(collision_c), 32'(pc));
      pv = vecs[k].ev; pd = vecs[k].ed; pc = vecs[k].ec;
    end

    // Streaming: fill 0..15, then 16 back-to-back reads
    idle_inputs();
    for (int a = 0; a < 16; a++) begin
      we = 1'b1; wr_addr = 4'(a); wr_data = 16'h0100 + 16'(a); wr_be = 2'b11;
      step();
    end
    idle_inputs();
    for (int a = 0; a < 16; a++) begin
      re = 1'b1; rd_addr = 4'(a);
      step();
      chk($sformatf("stream%0d_valid_a", a), 32'(rd_valid_a), 32'h1);
      chk($sformatf("stream%0d_data_a", a), 32'(rd_data_a), 32'h0100 + 32'(a));
      if (a >= 1) begin
        chk($sformatf("stream%0d_valid_c", a), 32'(rd_valid_c), 32'h1);
        chk($sformatf("stream%0d_data_c", a), 32'(rd_data_c), 32'h0100 + 32'(a - 1));
      end
    end
    re = 1'b0;
    step();
    chk("stream_end_valid_a", 32'(rd_valid_a), 32'h0);
    chk("stream_hold_data_a", 32'(rd_data_a), 32'h010F);
    chk("stream_last_valid_c", 32'(rd_valid_c), 32'h1);
    chk("stream_last_data_c", 32'(rd_data_c), 32'h010F);
    step();
    chk("stream_end_valid_c", 32'(rd_valid_c), 32'h0);
    chk("stream_hold_data_c", 32'(rd_data_c), 32'h010F);

    // Reset mid-INIT: preload mem[12], reset, abort clear at pointer 9
    we = 1'b1; wr_addr = 4'd12; wr_data = 16'hCAFE; wr_be = 2'b11;
    step();
    idle_inputs();
    re = 1'b1; rd_addr = 4'd12;
    step();
    chk("preload_data_a", 32'(rd_data_a), 32'hCAFE);
    re = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_rst_data_a", 32'(rd_data_a), 32'h0);
    chk("async_rst_valid_a", 32'(rd_valid_a), 32'h0);
    chk("async_rst_done_a", 32'(init_done_a), 32'h0);
    chk("async_rst_data_c", 32'(rd_data_c), 32'h0);
    step();
    reset = 1'b0;
    repeat (9) step();
    chk("midinit_done_a", 32'(init_done_a), 32'h0);
    reset = 1'b1;
    #1;
    chk("midinit_rst_done_a", 32'(init_done_a), 32'h0);
    chk("midinit_rst_valid_a", 32'(rd_valid_a), 32'h0);
    step();
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("reinit_done_a_e%0d", i), 32'(init_done_a), 32'(i == 16));
    end
    re = 1'b1; rd_addr = 4'd12;
    step();
    chk("cleared12_valid_a", 32'(rd_valid_a), 32'h1);
    chk("cleared12_data_a", 32'(rd_data_a), 32'h0);
    re = 1'b0;
    step();
    chk("cleared12_valid_c", 32'(rd_valid_c), 32'h1);
    chk("cleared12_data_c", 32'(rd_data_c), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
